// File: rtl/softmax_r2b_converter.sv
`default_nettype none
// ============================================================================
// Module  : softmax_r2b_converter
// Brief   : Collects softmax row slices into ping-pong tiles and emits each
//           full tile as BLOCK_SIZE x BLOCK_SIZE blocks in row-major order.
// Revision: 1.0
// ============================================================================
module softmax_r2b_converter #(
  parameter int WIDTH      = 16,
  parameter int ROWS       = 4,
  parameter int TILE_SIZE  = 8,
  parameter int BLOCK_SIZE = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [$clog2(ROWS):0]                  in_row_idx,
  input  logic [WIDTH*TILE_SIZE-1:0]             in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] out_data,
  output logic                                   out_last,
  output logic                                   err_dup,
  output logic                                   err_range
);

  localparam int IDX_W   = $clog2(ROWS) + 1;
  localparam int ROW_W   = $clog2(ROWS);
  localparam int SLICE_W = WIDTH * TILE_SIZE;
  localparam int NUM_BR  = ROWS / BLOCK_SIZE;
  localparam int NUM_BC  = TILE_SIZE / BLOCK_SIZE;
  localparam int BR_W    = (NUM_BR > 1) ? $clog2(NUM_BR) : 1;
  localparam int BC_W    = (NUM_BC > 1) ? $clog2(NUM_BC) : 1;

  localparam logic [IDX_W-1:0] ROWS_C = IDX_W'(ROWS);
  localparam logic [BR_W-1:0]  BR_MAX = BR_W'(NUM_BR - 1);
  localparam logic [BC_W-1:0]  BC_MAX = BC_W'(NUM_BC - 1);

  logic [SLICE_W-1:0] bank_q [2][ROWS];
  logic [ROWS-1:0]    row_mask_q [2];
  logic [ROWS-1:0]    row_mask_d [2];
  logic [1:0]         bank_full_q, bank_full_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [BR_W-1:0]    br_q, br_d;
  logic [BC_W-1:0]    bc_q, bc_d;
  logic               err_dup_q, err_dup_d;
  logic               err_range_q, err_range_d;

  logic               w_wr_fire;
  logic               w_rd_fire;
  logic               w_legal;
  logic [ROW_W-1:0]   w_row;
  logic [ROWS-1:0]    w_row_onehot;
  logic [ROWS-1:0]    w_mask_next;

  assign in_ready     = !bank_full_q[wr_bank_q];
  assign out_valid    = bank_full_q[rd_bank_q];
  assign out_last     = out_valid && (br_q == BR_MAX) && (bc_q == BC_MAX);
  assign err_dup      = err_dup_q;
  assign err_range    = err_range_q;

  assign w_wr_fire    = in_valid && in_ready;
  assign w_rd_fire    = out_valid && out_ready;
  assign w_legal      = (in_row_idx < ROWS_C);
  assign w_row        = in_row_idx[ROW_W-1:0];
  assign w_row_onehot = ROWS'(1) << w_row;
  assign w_mask_next  = row_mask_q[wr_bank_q] | w_row_onehot;

  always_comb begin
    row_mask_d  = row_mask_q;
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    br_d        = br_q;
    bc_d        = bc_q;
    err_dup_d   = err_dup_q;
    err_range_d = err_range_q;

    if (w_wr_fire) begin
      if (!w_legal) begin
        err_range_d = 1'b1;
      end else begin
        if ((row_mask_q[wr_bank_q] & w_row_onehot) != '0) begin
          err_dup_d = 1'b1;
        end
        // Completing the mask hands the bank to the read side.
        if (&w_mask_next) begin
          bank_full_d[wr_bank_q] = 1'b1;
          row_mask_d[wr_bank_q]  = '0;
          wr_bank_d              = !wr_bank_q;
        end else begin
          row_mask_d[wr_bank_q]  = w_mask_next;
        end
      end
    end

    // Write and read always target different banks, so both updates may land.
    if (w_rd_fire) begin
      if (bc_q == BC_MAX) begin
        bc_d = '0;
        if (br_q == BR_MAX) begin
          br_d                   = '0;
          bank_full_d[rd_bank_q] = 1'b0;
          rd_bank_d              = !rd_bank_q;
        end else begin
          br_d = br_q + 1'b1;
        end
      end else begin
        bc_d = bc_q + 1'b1;
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int r = 0; r < BLOCK_SIZE; r++) begin
      for (int c = 0; c < BLOCK_SIZE; c++) begin
        out_data[(r*BLOCK_SIZE+c)*WIDTH +: WIDTH] =
          bank_q[rd_bank_q][ROW_W'(int'(br_q)*BLOCK_SIZE + r)][(int'(bc_q)*BLOCK_SIZE + c)*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        row_mask_q[b] <= '0;
        for (int r = 0; r < ROWS; r++) begin
          bank_q[b][r] <= '0;
        end
      end
      bank_full_q <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      br_q        <= '0;
      bc_q        <= '0;
      err_dup_q   <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      if (w_wr_fire && w_legal) begin
        bank_q[wr_bank_q][w_row] <= in_data;
      end
      row_mask_q  <= row_mask_d;
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      br_q        <= br_d;
      bc_q        <= bc_d;
      err_dup_q   <= err_dup_d;
      err_range_q <= err_range_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_softmax_r2b_converter.sv
`default_nettype none
// ============================================================================
// Module  : tb_softmax_r2b_converter
// Brief   : Self-checking bench with a tile/block scoreboard model.
// Revision: 1.0
// ============================================================================
module tb_softmax_r2b_converter;

  localparam int W  = 16;
  localparam int R  = 4;
  localparam int T  = 8;
  localparam int B  = 2;
  localparam int IW = $clog2(R) + 1;
  localparam int DW = W * T;
  localparam int OW = W * B * B;
  localparam int NB = (R / B) * (T / B);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_row_idx = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          err_dup;
  logic          err_range;

  softmax_r2b_converter #(.WIDTH(W), .ROWS(R), .TILE_SIZE(T), .BLOCK_SIZE(B)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_row_idx(in_row_idx), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .err_dup(err_dup), .err_range(err_range)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the tile being assembled plus the queue of blocks owed.
  logic [W-1:0]  m_tile [R][T];
  bit            m_written [R];
  bit            m_dup, m_rng;
  bit            armed = 1'b0;
  logic [OW-1:0] exp_q[$];
  bit            explast_q[$];
  logic [OW-1:0] log_q[$];
  bit            loglast_q[$];
  bit            rand_rdy = 1'b0;

  function automatic void model_clear();
    exp_q.delete();
    explast_q.delete();
    for (int r = 0; r < R; r++) m_written[r] = 1'b0;
    m_dup = 1'b0;
    m_rng = 1'b0;
  endfunction

  function automatic void model_write(input int idx, input logic [DW-1:0] d);
    bit all;
    logic [OW-1:0] blk;
    if (idx >= R) begin
      m_rng = 1'b1;
      return;
    end
    if (m_written[idx]) m_dup = 1'b1;
    for (int c = 0; c < T; c++) m_tile[idx][c] = d[c*W +: W];
    m_written[idx] = 1'b1;
    all = 1'b1;
    for (int r = 0; r < R; r++) all &= m_written[r];
    if (!all) return;
    for (int br = 0; br < R / B; br++) begin
      for (int bc = 0; bc < T / B; bc++) begin
        for (int r = 0; r < B; r++)
          for (int c = 0; c < B; c++)
            blk[(r*B+c)*W +: W] = m_tile[br*B+r][bc*B+c];
        exp_q.push_back(blk);
        explast_q.push_back((br == R/B-1) && (bc == T/B-1));
      end
    end
    for (int r = 0; r < R; r++) m_written[r] = 1'b0;
  endfunction

  always @(negedge clk) begin
    int pend;
    if (armed) begin
      pend = (exp_q.size() + NB - 1) / NB;
      check("in_ready", in_ready, pend < 2);
      check("out_valid", out_valid, exp_q.size() > 0);
      check("err_dup", err_dup, m_dup);
      check("err_range", err_range, m_rng);
      if (exp_q.size() > 0) begin
        check("out_data", out_data, exp_q[0]);
        check("out_last", out_last, explast_q[0]);
      end else begin
        check("out_last_idle", out_last, 1'b0);
      end
    end
    if (!rst_n) begin
      model_clear();
      armed = 1'b1;
    end else if (armed) begin
      if (out_valid && out_ready && exp_q.size() > 0) begin
        log_q.push_back(out_data);
        loglast_q.push_back(out_last);
        void'(exp_q.pop_front());
        void'(explast_q.pop_front());
      end
      if (in_valid && in_ready) model_write(int'(in_row_idx), in_data);
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic logic [DW-1:0] row_pat(input int r);
    logic [DW-1:0] d;
    for (int c = 0; c < T; c++) d[c*W +: W] = W'(r * 16 + c);
    return d;
  endfunction

  function automatic logic [DW-1:0] row_rand();
    logic [DW-1:0] d;
    for (int c = 0; c < T; c++) d[c*W +: W] = W'($urandom);
    return d;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_row(input int idx, input logic [DW-1:0] d);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    in_valid   = 1'b1;
    in_row_idx = IW'(idx);
    in_data    = d;
    while (!ok && n < 2000) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() > 0) check("drain_timeout", 1'b0, 1'b1);
  endtask

  logic [OW-1:0] ref_blk [NB];
  int            nlast;
  int            perm [R];
  int            tmp, j;

  initial begin
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_errs", {err_dup, err_range}, 2'b00);
    @(posedge clk);
    #1;

    // In-order tile
    out_ready = 1'b1;
    log_q.delete();
    loglast_q.delete();
    for (int r = 0; r < R; r++) send_row(r, row_pat(r));
    wait_drain();
    check("inord_count", log_q.size(), NB);
    if (log_q.size() == NB) begin
      check("blk0", log_q[0], 64'h0011_0010_0001_0000);
      check("blk1", log_q[1], 64'h0013_0012_0003_0002);
      check("blk4", log_q[4], 64'h0031_0030_0021_0020);
      nlast = 0;
      for (int i = 0; i < NB; i++) nlast += int'(loglast_q[i]);
      check("last_count", nlast, 1);
      check("last_on_blk7", loglast_q[NB-1], 1'b1);
      for (int i = 0; i < NB; i++) ref_blk[i] = log_q[i];
    end

    // Out-of-order rows must give an identical tile
    log_q.delete();
    loglast_q.delete();
    send_row(3, row_pat(3));
    send_row(1, row_pat(1));
    send_row(0, row_pat(0));
    send_row(2, row_pat(2));
    wait_drain();
    check("ooo_count", log_q.size(), NB);
    if (log_q.size() == NB)
      for (int i = 0; i < NB; i++) check("ooo_blk", log_q[i], ref_blk[i]);

    // Backpressure: both banks fill, ninth row held until drain
    out_ready = 1'b0;
    for (int t = 0; t < 2; t++)
      for (int r = 0; r < R; r++) send_row(r, row_rand());
    @(negedge clk);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;
    fork
      send_row(0, row_rand());
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    for (int r = 1; r < R; r++) send_row(r, row_rand());
    wait_drain();

    // Duplicate and out-of-range rows
    log_q.delete();
    loglast_q.delete();
    send_row(1, row_pat(1));
    send_row(1, {T{16'hAAAA}});
    send_row(5, row_rand());
    send_row(0, row_pat(0));
    send_row(2, row_pat(2));
    send_row(3, row_pat(3));
    wait_drain();
    check("dup_flag", err_dup, 1'b1);
    check("range_flag", err_range, 1'b1);
    check("dup_count", log_q.size(), NB);
    if (log_q.size() > 0) check("dup_blk0", log_q[0], 64'hAAAA_AAAA_0001_0000);

    // Reset mid-tile, then a fresh tile
    send_row(0, row_rand());
    send_row(1, row_rand());
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    log_q.delete();
    loglast_q.delete();
    @(negedge clk);
    check("rst2_flags", {err_dup, err_range, out_valid}, 3'b000);
    @(posedge clk);
    #1;
    for (int r = R - 1; r >= 0; r--) send_row(r, row_rand());
    wait_drain();
    check("rst2_count", log_q.size(), NB);

    // Random tiles, shuffled row order, random gaps and backpressure
    rand_rdy = 1'b1;
    for (int t = 0; t < 20; t++) begin
      for (int r = 0; r < R; r++) perm[r] = r;
      for (int r = R - 1; r > 0; r--) begin
        j = $urandom_range(0, r);
        tmp = perm[r];
        perm[r] = perm[j];
        perm[j] = tmp;
      end
      for (int r = 0; r < R; r++) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        send_row(perm[r], row_rand());
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    wait_drain();
    check("final_empty", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
